stack_tracker: RTL and testbench

STACK_TRACKER -- requirements
Module: stack_tracker

---
 rtl/stack_tracker.sv | 233 +++++++++++++++++++++++
 tb/tb_stack_tracker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_tracker.sv
// Stacking-game tracker: compares each stopped block span with the top of the stack and records the overlap.
// Optional macro STACK_PERFECT_GROW_EN grows the span by one unit on a perfectly aligned stop.
module stack_tracker #(
  parameter int X_W        = 9,
  parameter int SIZE_W     = 4,
  parameter int LEVELS     = 16,
  parameter int LVL_W      = $clog2(LEVELS),
  parameter int UNIT_LOG2  = 3,
  parameter int INIT_START = 100,
  parameter int INIT_END   = 163
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              stop_valid,
  output logic              stop_ready,
  input  logic [X_W-1:0]    curr_start,
  input  logic [X_W-1:0]    curr_end,
  output logic [X_W-1:0]    prev_start,
  output logic [X_W-1:0]    prev_end,
  output logic [SIZE_W-1:0] prev_size,
  output logic [LVL_W-1:0]  level,
  output logic              result_valid,
  output logic              perfect,
  output logic              game_over,
  input  logic [LVL_W-1:0]  rd_level,
  output logic [X_W-1:0]    rd_start,
  output logic [X_W-1:0]    rd_end
);

  // States: IDLE accept stop | CMP overlap | UPD commit | OVER wait for clear
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_UPD  = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  localparam logic [SIZE_W-1:0] SIZE_MAX = '1;
  localparam logic [X_W-1:0]    BASE_S   = X_W'(INIT_START);
  localparam logic [X_W-1:0]    BASE_E   = X_W'(INIT_END);
  localparam logic [SIZE_W-1:0] BASE_SZ  = SIZE_W'((INIT_END - INIT_START + 1) >> UNIT_LOG2);
  localparam logic [LVL_W-1:0]  TOP_LVL  = LVL_W'(LEVELS - 1);

  logic [1:0]        state_q, state_d;
  logic [X_W-1:0]    cur_s_q, cur_s_d, cur_e_q, cur_e_d;
  logic [X_W-1:0]    ov_s_q, ov_s_d, ov_e_q, ov_e_d;
  logic [SIZE_W-1:0] sz_q, sz_d;
  logic              miss_q, miss_d, perf_q, perf_d;
  logic [X_W-1:0]    prev_s_q, prev_s_d, prev_e_q, prev_e_d;
  logic [SIZE_W-1:0] prev_sz_q, prev_sz_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              rv_q, rv_d, perfect_q, perfect_d, over_q, over_d;
  logic              hist_we;
  logic [X_W-1:0]    hist_s_q [LEVELS];
  logic [X_W-1:0]    hist_e_q [LEVELS];
  logic [X_W-1:0]    rd_s_q, rd_e_q;

  logic [X_W-1:0]    ov_s, ov_e;
  logic [X_W:0]      ov_w, raw_sz;
  logic [SIZE_W-1:0] sat_sz;
  logic              cmp_miss, cmp_perf;
  logic [X_W-1:0]    new_e;
  logic [SIZE_W-1:0] new_sz;
  logic [LVL_W-1:0]  lvl_nxt;

  assign ov_s     = (prev_s_q > cur_s_q) ? prev_s_q : cur_s_q;
  assign ov_e     = (prev_e_q < cur_e_q) ? prev_e_q : cur_e_q;
  assign ov_w     = {1'b0, ov_e} - {1'b0, ov_s} + (X_W+1)'(1);
  assign raw_sz   = ov_w >> UNIT_LOG2;
  assign sat_sz   = (raw_sz > (X_W+1)'(SIZE_MAX)) ? SIZE_MAX : raw_sz[SIZE_W-1:0];
  // An overlap narrower than one size unit counts as a miss.
  assign cmp_miss = (ov_s > ov_e) || (cur_s_q > cur_e_q) || (raw_sz == '0);
  assign cmp_perf = (cur_s_q == prev_s_q) && (cur_e_q == prev_e_q);
  assign lvl_nxt  = level_q + LVL_W'(1);

`ifdef STACK_PERFECT_GROW_EN
  localparam logic [X_W:0]   UNIT_PX = (X_W+1)'(1) << UNIT_LOG2;
  localparam logic [X_W-1:0] X_MAX   = '1;
  logic [X_W:0] grow_e;
  assign grow_e = {1'b0, ov_e_q} + UNIT_PX;
  assign new_e  = !perf_q ? ov_e_q : (grow_e[X_W] ? X_MAX : grow_e[X_W-1:0]);
  assign new_sz = (perf_q && sz_q != SIZE_MAX) ? sz_q + SIZE_W'(1) : sz_q;
`else
  assign new_e  = ov_e_q;
  assign new_sz = sz_q;
`endif

  always_comb begin
    state_d   = state_q;
    cur_s_d   = cur_s_q;
    cur_e_d   = cur_e_q;
    ov_s_d    = ov_s_q;
    ov_e_d    = ov_e_q;
    sz_d      = sz_q;
    miss_d    = miss_q;
    perf_d    = perf_q;
    prev_s_d  = prev_s_q;
    prev_e_d  = prev_e_q;
    prev_sz_d = prev_sz_q;
    level_d   = level_q;
    rv_d      = 1'b0;
    perfect_d = perfect_q;
    over_d    = over_q;
    hist_we   = 1'b0;
    if (clear) begin
      state_d   = S_IDLE;
      cur_s_d   = '0;
      cur_e_d   = '0;
      ov_s_d    = '0;
      ov_e_d    = '0;
      sz_d      = '0;
      miss_d    = 1'b0;
      perf_d    = 1'b0;
      prev_s_d  = BASE_S;
      prev_e_d  = BASE_E;
      prev_sz_d = BASE_SZ;
      level_d   = '0;
      perfect_d = 1'b0;
      over_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (stop_valid) begin
          cur_s_d = curr_start;
          cur_e_d = curr_end;
          state_d = S_CMP;
        end
        S_CMP: begin
          ov_s_d  = ov_s;
          ov_e_d  = ov_e;
          sz_d    = sat_sz;
          miss_d  = cmp_miss;
          perf_d  = cmp_perf;
          state_d = S_UPD;
        end
        S_UPD: begin
          rv_d      = 1'b1;
          perfect_d = perf_q && !miss_q;
          if (miss_q) begin
            over_d  = 1'b1;
            state_d = S_OVER;
          end else begin
            prev_s_d  = ov_s_q;
            prev_e_d  = new_e;
            prev_sz_d = new_sz;
            level_d   = lvl_nxt;
            hist_we   = 1'b1;
            if (lvl_nxt == TOP_LVL) begin
              over_d  = 1'b1;
              state_d = S_OVER;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_OVER: state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cur_s_q   <= '0;
      cur_e_q   <= '0;
      ov_s_q    <= '0;
      ov_e_q    <= '0;
      sz_q      <= '0;
      miss_q    <= 1'b0;
      perf_q    <= 1'b0;
      prev_s_q  <= BASE_S;
      prev_e_q  <= BASE_E;
      prev_sz_q <= BASE_SZ;
      level_q   <= '0;
      rv_q      <= 1'b0;
      perfect_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_s_q   <= cur_s_d;
      cur_e_q   <= cur_e_d;
      ov_s_q    <= ov_s_d;
      ov_e_q    <= ov_e_d;
      sz_q      <= sz_d;
      miss_q    <= miss_d;
      perf_q    <= perf_d;
      prev_s_q  <= prev_s_d;
      prev_e_q  <= prev_e_d;
      prev_sz_q <= prev_sz_d;
      level_q   <= level_d;
      rv_q      <= rv_d;
      perfect_q <= perfect_d;
      over_q    <= over_d;
    end
  end

  // History and its read port: a same-cycle write is not visible to the read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LEVELS; i++) begin
        hist_s_q[i] <= (i == 0) ? BASE_S : '0;
        hist_e_q[i] <= (i == 0) ? BASE_E : '0;
      end
      rd_s_q <= '0;
      rd_e_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < LEVELS; i++) begin
        hist_s_q[i] <= (i == 0) ? BASE_S : '0;
        hist_e_q[i] <= (i == 0) ? BASE_E : '0;
      end
      rd_s_q <= '0;
      rd_e_q <= '0;
    end else begin
      if (hist_we) begin
        hist_s_q[lvl_nxt] <= ov_s_q;
        hist_e_q[lvl_nxt] <= new_e;
      end
      rd_s_q <= (rd_level > level_q) ? '0 : hist_s_q[rd_level];
      rd_e_q <= (rd_level > level_q) ? '0 : hist_e_q[rd_level];
    end
  end

  assign stop_ready   = (state_q == S_IDLE);
  assign prev_start   = prev_s_q;
  assign prev_end     = prev_e_q;
  assign prev_size    = prev_sz_q;
  assign level        = level_q;
  assign result_valid = rv_q;
  assign perfect      = perfect_q;
  assign game_over    = over_q;
  assign rd_start     = rd_s_q;
  assign rd_end       = rd_e_q;

endmodule

// File: tb/tb_stack_tracker.sv
// Self-checking bench for stack_tracker: directed scenarios plus random stops against a span-arithmetic model.
module tb_stack_tracker;
  localparam int X_W = 9, SIZE_W = 4, LEVELS = 16, LVL_W = 4, U = 3;
  localparam int XMAX = (1 << X_W) - 1, SMAX = (1 << SIZE_W) - 1;

  logic clk = 1'b0, resetn = 1'b0, clear = 1'b0, stop_valid = 1'b0;
  logic [X_W-1:0] curr_start = '0, curr_end = '0;
  logic [LVL_W-1:0] rd_level = '0;
  logic stop_ready, result_valid, perfect, game_over;
  logic [X_W-1:0] prev_start, prev_end, rd_start, rd_end;
  logic [SIZE_W-1:0] prev_size;
  logic [LVL_W-1:0] level;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  int m_ps, m_pe, m_sz, m_lvl;
  bit m_over;
  int m_hs [LEVELS];
  int m_he [LEVELS];

  stack_tracker dut (
    .clk(clk), .resetn(resetn), .clear(clear), .stop_valid(stop_valid),
    .stop_ready(stop_ready), .curr_start(curr_start), .curr_end(curr_end),
    .prev_start(prev_start), .prev_end(prev_end), .prev_size(prev_size),
    .level(level), .result_valid(result_valid), .perfect(perfect),
    .game_over(game_over), .rd_level(rd_level), .rd_start(rd_start), .rd_end(rd_end)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_ps = 100; m_pe = 163; m_sz = (163 - 100 + 1) / (1 << U); m_lvl = 0; m_over = 0;
    for (int i = 0; i < LEVELS; i++) begin m_hs[i] = 0; m_he[i] = 0; end
    m_hs[0] = 100; m_he[0] = 163;
  endfunction

  function automatic void model_stop(input int cs, input int ce, output bit perf, output bit miss);
    int os, oe, sz;
    os = (cs > m_ps) ? cs : m_ps;
    oe = (ce < m_pe) ? ce : m_pe;
    perf = (cs == m_ps) && (ce == m_pe);
    miss = (cs > ce) || (os > oe);
    sz = 0;
    if (!miss) begin
      sz = (oe - os + 1) / (1 << U);
      if (sz == 0) miss = 1;
    end
    if (miss) begin perf = 0; m_over = 1; return; end
    if (sz > SMAX) sz = SMAX;
`ifdef STACK_PERFECT_GROW_EN
    if (perf) begin
      oe = (oe + (1 << U) > XMAX) ? XMAX : oe + (1 << U);
      sz = (sz < SMAX) ? sz + 1 : SMAX;
    end
`endif
    m_ps = os; m_pe = oe; m_sz = sz; m_lvl++;
    m_hs[m_lvl] = os; m_he[m_lvl] = oe;
    if (m_lvl == LEVELS - 1) m_over = 1;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; clear = 1'b0; stop_valid = 1'b0; rd_level = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  // Presents one stop for a single cycle; lat = edges from accept to result_valid, -1 if none.
  task automatic send_stop(input int cs, input int ce, output int lat);
    @(negedge clk);
    stop_valid = 1'b1; curr_start = X_W'(cs); curr_end = X_W'(ce);
    @(posedge clk);
    @(negedge clk);
    stop_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (stop_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", stop_ready); end
    n_cmp++; if (prev_start !== 9'd100 || prev_end !== 9'd163) begin n_err++; $display("FAIL reset_span got %0d..%0d want 100..163", prev_start, prev_end); end
    n_cmp++; if (prev_size !== 4'd8 || level !== 4'd0) begin n_err++; $display("FAIL reset_size_level got %0d/%0d want 8/0", prev_size, level); end
    n_cmp++; if (result_valid !== 1'b0 || perfect !== 1'b0 || game_over !== 1'b0) begin n_err++; $display("FAIL reset_flags got rv%0b p%0b go%0b want 0", result_valid, perfect, game_over); end
    n_cmp++; if (rd_start !== '0 || rd_end !== '0) begin n_err++; $display("FAIL reset_rd got %0d..%0d want 0..0", rd_start, rd_end); end
    @(posedge clk); #1;
    n_cmp++; if (rd_start !== 9'd100 || rd_end !== 9'd163) begin n_err++; $display("FAIL reset_hist0 got %0d..%0d want 100..163", rd_start, rd_end); end
  endtask

  task automatic test_basic_hit();
    int lat;
    do_reset();
    send_stop(108, 171, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL hit_latency got %0d want 2", lat); end
    n_cmp++; if (prev_start !== 9'd108 || prev_end !== 9'd163) begin n_err++; $display("FAIL hit_span got %0d..%0d want 108..163", prev_start, prev_end); end
    n_cmp++; if (prev_size !== 4'd7 || level !== 4'd1) begin n_err++; $display("FAIL hit_size_level got %0d/%0d want 7/1", prev_size, level); end
    n_cmp++; if (perfect !== 1'b0 || game_over !== 1'b0) begin n_err++; $display("FAIL hit_flags got p%0b go%0b want 0/0", perfect, game_over); end
    @(posedge clk); #1;
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL hit_pulse_width got %0b want 0", result_valid); end
    @(negedge clk); rd_level = 4'd1;
    @(posedge clk); #1;
    n_cmp++; if (rd_start !== 9'd108 || rd_end !== 9'd163) begin n_err++; $display("FAIL rd_lvl1 got %0d..%0d want 108..163", rd_start, rd_end); end
    @(negedge clk); rd_level = 4'd2;
    @(posedge clk); #1;
    n_cmp++; if (rd_start !== '0 || rd_end !== '0) begin n_err++; $display("FAIL rd_lvl2 got %0d..%0d want 0..0", rd_start, rd_end); end
    @(negedge clk); rd_level = 4'd0;
    @(posedge clk); #1;
    n_cmp++; if (rd_start !== 9'd100 || rd_end !== 9'd163) begin n_err++; $display("FAIL rd_lvl0 got %0d..%0d want 100..163", rd_start, rd_end); end
  endtask

  task automatic test_perfect();
    int lat; bit ep, em;
    do_reset();
    model_stop(100, 163, ep, em);
    send_stop(100, 163, lat);
    n_cmp++; if (lat !== 2 || perfect !== 1'b1) begin n_err++; $display("FAIL perfect_flag got lat%0d p%0b want lat2 p1", lat, perfect); end
`ifdef STACK_PERFECT_GROW_EN
    n_cmp++; if (prev_start !== 9'd100 || prev_end !== 9'd171 || prev_size !== 4'd9) begin n_err++; $display("FAIL perfect_grow got %0d..%0d sz%0d want 100..171 sz9", prev_start, prev_end, prev_size); end
`else
    n_cmp++; if (prev_start !== 9'd100 || prev_end !== 9'd163 || prev_size !== 4'd8) begin n_err++; $display("FAIL perfect_plain got %0d..%0d sz%0d want 100..163 sz8", prev_start, prev_end, prev_size); end
`endif
    n_cmp++; if (level !== 4'(m_lvl) || prev_end !== 9'(m_pe)) begin n_err++; $display("FAIL perfect_model got lvl%0d end%0d want lvl%0d end%0d", level, prev_end, m_lvl, m_pe); end
  endtask

  task automatic test_miss();
    int lat, rv_seen;
    do_reset();
    send_stop(200, 263, lat);
    n_cmp++; if (lat !== 2 || game_over !== 1'b1 || perfect !== 1'b0) begin n_err++; $display("FAIL miss_flags got lat%0d go%0b p%0b want 2/1/0", lat, game_over, perfect); end
    n_cmp++; if (prev_start !== 9'd100 || prev_end !== 9'd163 || level !== 4'd0) begin n_err++; $display("FAIL miss_span got %0d..%0d lvl%0d want 100..163 lvl0", prev_start, prev_end, level); end
    @(negedge clk); stop_valid = 1'b1; curr_start = 9'd100; curr_end = 9'd163;
    rv_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (result_valid || stop_ready) rv_seen++;
    end
    n_cmp++; if (rv_seen !== 0) begin n_err++; $display("FAIL over_ignores_stop got %0d active cycles want 0", rv_seen); end
    @(negedge clk); stop_valid = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    n_cmp++; if (game_over !== 1'b0 || stop_ready !== 1'b1 || prev_end !== 9'd163 || prev_size !== 4'd8) begin n_err++; $display("FAIL miss_clear got go%0b rdy%0b end%0d sz%0d want 0/1/163/8", game_over, stop_ready, prev_end, prev_size); end
  endtask

  task automatic test_small_overlap();
    int lat;
    do_reset();
    send_stop(160, 223, lat);
    n_cmp++; if (lat !== 2 || game_over !== 1'b1 || level !== 4'd0 || prev_start !== 9'd100) begin n_err++; $display("FAIL small_overlap got lat%0d go%0b lvl%0d st%0d want 2/1/0/100", lat, game_over, level, prev_start); end
  endtask

  task automatic test_full_stack();
    int lat, bad, rv_seen; bit ep, em;
    do_reset();
    bad = 0;
    for (int i = 0; i < LEVELS - 1; i++) begin
      int cs, ce;
      cs = m_ps; ce = m_pe;
      model_stop(cs, ce, ep, em);
      send_stop(cs, ce, lat);
      if (lat !== 2 || level !== 4'(m_lvl) || game_over !== m_over || perfect !== 1'b1) begin
        bad++;
        $display("FAIL full_step%0d got lat%0d lvl%0d go%0b p%0b want 2/%0d/%0b/1", i, lat, level, game_over, perfect, m_lvl, m_over);
      end
    end
    n_cmp++; if (bad !== 0) n_err++;
    n_cmp++; if (level !== 4'd15 || game_over !== 1'b1) begin n_err++; $display("FAIL full_final got lvl%0d go%0b want 15/1", level, game_over); end
    @(negedge clk); stop_valid = 1'b1; curr_start = X_W'(m_ps); curr_end = X_W'(m_pe);
    rv_seen = 0;
    repeat (5) begin @(posedge clk); #1; if (result_valid || stop_ready) rv_seen++; end
    @(negedge clk); stop_valid = 1'b0;
    n_cmp++; if (rv_seen !== 0 || level !== 4'd15) begin n_err++; $display("FAIL full_16th got active%0d lvl%0d want 0/15", rv_seen, level); end
  endtask

  task automatic test_clear_priority();
    int rv_seen;
    do_reset();
    @(negedge clk); clear = 1'b1; stop_valid = 1'b1; curr_start = 9'd108; curr_end = 9'd171;
    @(posedge clk); #1;
    n_cmp++; if (stop_ready !== 1'b1 || result_valid !== 1'b0 || level !== 4'd0) begin n_err++; $display("FAIL clear_vs_stop got rdy%0b rv%0b lvl%0d want 1/0/0", stop_ready, result_valid, level); end
    @(negedge clk); clear = 1'b0; stop_valid = 1'b0;
    rv_seen = 0;
    repeat (4) begin @(posedge clk); #1; if (result_valid) rv_seen++; end
    n_cmp++; if (rv_seen !== 0) begin n_err++; $display("FAIL clear_no_result got %0d pulses want 0", rv_seen); end
    @(negedge clk); stop_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); stop_valid = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    rv_seen = 0;
    repeat (4) begin @(posedge clk); #1; if (result_valid) rv_seen++; end
    n_cmp++; if (rv_seen !== 0 || prev_start !== 9'd100 || level !== 4'd0) begin n_err++; $display("FAIL clear_mid_cmp got pulses%0d st%0d lvl%0d want 0/100/0", rv_seen, prev_start, level); end
    @(negedge clk); stop_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); stop_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    #1;
    n_cmp++; if (prev_start !== 9'd100 || level !== 4'd0 || result_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_upd got st%0d lvl%0d rv%0b want 100/0/0", prev_start, level, result_valid); end
    @(negedge clk); resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int lat, cs, ce, r, rl, bad, nstop; bit ep, em;
    do_reset();
    bad = 0; nstop = 0;
    for (int n = 0; n < 60; n++) begin
      if (m_over) begin
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_reset();
      end
      r = $urandom_range(0, 9);
      if (r < 3) begin
        cs = m_ps; ce = m_pe;
      end else if (r == 3) begin
        cs = $urandom_range(0, XMAX); ce = $urandom_range(0, XMAX);
      end else begin
        cs = m_ps + $urandom_range(0, 12) - 6;
        ce = m_pe + $urandom_range(0, 12) - 6;
        if (cs < 0) cs = 0;
        if (ce > XMAX) ce = XMAX;
      end
      if (stop_ready !== 1'b1) begin bad++; $display("FAIL rand_ready%0d got %0b want 1", n, stop_ready); end
      model_stop(cs, ce, ep, em);
      send_stop(cs, ce, lat);
      nstop++;
      if (lat !== 2 || perfect !== ep || game_over !== m_over ||
          prev_start !== 9'(m_ps) || prev_end !== 9'(m_pe) ||
          prev_size !== 4'(m_sz) || level !== 4'(m_lvl)) begin
        bad++;
        $display("FAIL rand_stop%0d %0d..%0d got lat%0d p%0b go%0b %0d..%0d sz%0d lvl%0d want 2 p%0b go%0b %0d..%0d sz%0d lvl%0d",
                 n, cs, ce, lat, perfect, game_over, prev_start, prev_end, prev_size, level,
                 ep, m_over, m_ps, m_pe, m_sz, m_lvl);
      end
      rl = $urandom_range(0, LEVELS - 1);
      @(negedge clk); rd_level = 4'(rl);
      @(posedge clk); #1;
      if (rd_start !== 9'((rl > m_lvl) ? 0 : m_hs[rl]) || rd_end !== 9'((rl > m_lvl) ? 0 : m_he[rl])) begin
        bad++;
        $display("FAIL rand_read lvl%0d got %0d..%0d want %0d..%0d", rl, rd_start, rd_end,
                 (rl > m_lvl) ? 0 : m_hs[rl], (rl > m_lvl) ? 0 : m_he[rl]);
      end
    end
    n_cmp += 3 * nstop;
    n_err += bad;
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_perfect();
    test_miss();
    test_small_overlap();
    test_full_stack();
    test_clear_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
